frame_source_scheduler: RTL and testbench

- Frame-aligned arbiter between several Avalon-ST pixel sources (ROM image streamers, pattern generators) and the single VGA sink.
- Forwards exactly one source at a time.
- Changes source only on frame boundaries, so the sink never sees a torn or partial frame.
- Sits between the image streamers and the VGA output module; pass-through with zero added latency.

---
 rtl/frame_source_scheduler.sv | 165 ++++++++++++++++
 tb/tb_frame_source_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/frame_source_scheduler.sv
// rtl/frame_source_scheduler.sv - frame-aligned zero-latency arbiter from several pixel streams to one VGA sink.
// Optional frame length checker enabled by FRAME_LENGTH_CHECK_EN.
module frame_source_scheduler #(
    parameter int NumSources = 3,
    parameter int DataWidth  = 3,
    parameter int NumPixels  = 640*480,
    localparam int SelWidth  = (NumSources > 1) ? $clog2(NumSources) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [SelWidth-1:0]             sel,
    input  logic [NumSources*DataWidth-1:0] in_data,
    input  logic [NumSources-1:0]           in_valid,
    input  logic [NumSources-1:0]           in_startofpacket,
    input  logic [NumSources-1:0]           in_endofpacket,
    output logic [NumSources-1:0]           in_ready,
    output logic [DataWidth-1:0]            out_data,
    output logic                            out_valid,
    output logic                            out_startofpacket,
    output logic                            out_endofpacket,
    input  logic                            out_ready,
    output logic [SelWidth-1:0]             active_sel,
    output logic                            syncing
`ifdef FRAME_LENGTH_CHECK_EN
    ,
    output logic                            length_error
`endif
);

    typedef enum logic {SYNC = 1'b0, STREAM = 1'b1} state_t;

    localparam logic [SelWidth:0] NumSrcW = NumSources[SelWidth:0];

    state_t              state_q, state_d;
    logic [SelWidth-1:0] active_sel_q, active_sel_d;
    logic [SelWidth-1:0] pending_sel_q, pending_sel_d;
    logic                pending_q, pending_d;

    logic [DataWidth-1:0] cur_data;
    logic                 cur_valid, cur_sop, cur_eop;
    logic                 sync_fwd, act_ready, handshake, sel_ok;

    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        cur_sop   = 1'b0;
        cur_eop   = 1'b0;
        for (int i = 0; i < NumSources; i++) begin
            if (active_sel_q == SelWidth'(i)) begin
                cur_data  = in_data[i*DataWidth +: DataWidth];
                cur_valid = in_valid[i];
                cur_sop   = in_startofpacket[i];
                cur_eop   = in_endofpacket[i];
            end
        end
    end

    // In SYNC only a start-of-frame beat is offered to the sink; everything else is drained.
    assign sync_fwd  = (state_q == SYNC) && cur_valid && cur_sop;
    assign act_ready = ((state_q == STREAM) || sync_fwd) ? out_ready : 1'b1;

    assign out_data          = cur_data;
    assign out_valid         = !reset && ((state_q == STREAM) ? cur_valid : sync_fwd);
    assign out_startofpacket = out_valid && cur_sop;
    assign out_endofpacket   = out_valid && cur_eop;
    assign handshake         = out_valid && out_ready;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NumSources; i++) begin
            if (!reset && (active_sel_q == SelWidth'(i))) begin
                in_ready[i] = act_ready;
            end
        end
    end

    assign sel_ok     = ({1'b0, sel} < NumSrcW);
    assign active_sel = active_sel_q;
    assign syncing    = (state_q == SYNC);

    // pending_q always equals (pending_sel_q != active_sel_q); pending_sel_q is the last legal request.
    always_comb begin
        state_d       = state_q;
        active_sel_d  = active_sel_q;
        pending_d     = pending_q;
        pending_sel_d = pending_sel_q;
        if (sel_ok) begin
            pending_sel_d = sel;
            pending_d     = (sel != active_sel_q);
        end
        case (state_q)
            SYNC: begin
                if (handshake) begin
                    state_d = STREAM;
                end else begin
                    active_sel_d = pending_sel_d;
                    pending_d    = 1'b0;
                end
            end
            STREAM: begin
                if (handshake && cur_eop && pending_q) begin
                    state_d      = SYNC;
                    active_sel_d = pending_sel_q;
                    pending_d    = sel_ok && (sel != pending_sel_q);
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SYNC;
            active_sel_q  <= '0;
            pending_q     <= 1'b0;
            pending_sel_q <= '0;
        end else begin
            state_q       <= state_d;
            active_sel_q  <= active_sel_d;
            pending_q     <= pending_d;
            pending_sel_q <= pending_sel_d;
        end
    end

`ifdef FRAME_LENGTH_CHECK_EN
    localparam int CntWidth = (NumPixels > 1) ? $clog2(NumPixels) : 1;
    localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NumPixels - 1);

    logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;
    logic                len_err_q, len_err_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        if (handshake) begin
            if (out_startofpacket) begin
                beat_cnt_d = '0;
                if (out_endofpacket && (LastIdx != '0)) begin
                    len_err_d = 1'b1;
                end
            end else if (beat_cnt_q == LastIdx) begin
                len_err_d = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (out_endofpacket && (beat_cnt_d != LastIdx)) begin
                    len_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign length_error = len_err_q;
`endif

endmodule

// File: tb/tb_frame_source_scheduler.sv
// tb/tb_frame_source_scheduler.sv - randomized bench for frame_source_scheduler against a frame-level model.
module tb_frame_source_scheduler;

    localparam int NS = 3;
    localparam int DW = 8;
    localparam int NP = 16;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [SW-1:0]  sel;
    logic [NS*DW-1:0] in_data;
    logic [NS-1:0]  in_valid, in_sop, in_eop, in_ready;
    logic [DW-1:0]  out_data;
    logic           out_valid, out_sop, out_eop, out_ready;
    logic [SW-1:0]  active_sel;
    logic           syncing;
`ifdef FRAME_LENGTH_CHECK_EN
    logic           length_error;
`endif

    always #5 clk = ~clk;

    frame_source_scheduler #(
        .NumSources (NS),
        .DataWidth  (DW),
        .NumPixels  (NP)
    ) dut (
        .clk               (clk),
        .reset             (rst),
        .sel               (sel),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_ready         (out_ready),
        .active_sel        (active_sel),
        .syncing           (syncing)
`ifdef FRAME_LENGTH_CHECK_EN
        ,
        .length_error      (length_error)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sources: each walks pixel positions 0..flen-1 and advances on its own handshake.
    int pos[NS];
    int flen[NS];

    // Model: owner = source holding the sink, want = last legal request, hunting = waiting for a sop.
    int owner, want, idx;
    bit hunting, lerr;
    bit e_valid;
    logic [NS-1:0] e_ready;

    task automatic model_reset();
        owner = 0; want = 0; hunting = 1'b1; idx = 0; lerr = 1'b0;
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NS; i++) begin
            in_data[i*DW +: DW] = DW'((i << 4) | pos[i]);
            in_sop[i]   = (pos[i] == 0);
            in_eop[i]   = (pos[i] == flen[i] - 1);
            in_valid[i] = ($urandom_range(0, 9) < 8);
        end
    endtask

    task automatic predict();
        bit rdy;
        if (hunting) begin
            e_valid = in_valid[owner] && in_sop[owner];
            rdy     = e_valid ? out_ready : 1'b1;
        end else begin
            e_valid = in_valid[owner];
            rdy     = out_ready;
        end
        e_ready = '0;
        e_ready[owner] = rdy;
    endtask

    task automatic advance();
        bit hs, c_sop, c_eop;
        int want_old;
        hs    = e_valid && out_ready;
        c_sop = in_sop[owner];
        c_eop = in_eop[owner];
        for (int i = 0; i < NS; i++)
            if (in_valid[i] && e_ready[i]) pos[i] = (pos[i] + 1) % flen[i];
        if (hs) begin
            if (c_sop) idx = 0;
            else idx = idx + 1;
            if (idx > NP - 1 || (c_eop && idx != NP - 1)) lerr = 1'b1;
        end
        want_old = want;
        if (int'(sel) < NS) want = int'(sel);
        if (hunting) begin
            if (hs) hunting = 1'b0;
            else owner = want;
        end else if (hs && c_eop && want_old != owner) begin
            owner   = want_old;
            hunting = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            flen[i] = NP;
            pos[i]  = $urandom_range(0, NP - 1);
        end
`ifdef FRAME_LENGTH_CHECK_EN
        flen[2] = 12;
        pos[2]  = pos[2] % 12;
`endif
        rst = 1'b1; sel = '0; out_ready = 1'b1;
        in_data = '0; in_valid = '0; in_sop = '0; in_eop = '0;
        model_reset();
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = (cyc < 3) || (cyc >= 1500 && cyc < 1502) || (cyc == 3000);
            if (cyc >= 200 && $urandom_range(0, 99) < 3) sel = SW'($urandom_range(0, 3));
            if (cyc >= 300 && cyc < 304) out_ready = 1'b0;
            else if (cyc < 200) out_ready = 1'b1;
            else out_ready = ($urandom_range(0, 3) != 0);
            drive_sources();
            #4;
            if (rst) begin
                check_eq("rst_out_valid", 32'(out_valid), 32'd0);
                check_eq("rst_in_ready",  32'(in_ready),  32'd0);
                check_eq("rst_out_sop",   32'(out_sop),   32'd0);
                check_eq("rst_out_eop",   32'(out_eop),   32'd0);
                check_eq("rst_syncing",   32'(syncing),   32'd1);
                check_eq("rst_active",    32'(active_sel), 32'd0);
`ifdef FRAME_LENGTH_CHECK_EN
                check_eq("rst_length_error", 32'(length_error), 32'd0);
`endif
            end else begin
                predict();
                check_eq("out_valid",  32'(out_valid),  32'(e_valid));
                check_eq("in_ready",   32'(in_ready),   32'(e_ready));
                check_eq("syncing",    32'(syncing),    32'(hunting));
                check_eq("active_sel", 32'(active_sel), 32'(owner));
                if (e_valid) begin
                    check_eq("out_data", 32'(out_data), 32'((owner << 4) | pos[owner]));
                    check_eq("out_sop",  32'(out_sop),  32'(pos[owner] == 0));
                    check_eq("out_eop",  32'(out_eop),  32'(pos[owner] == flen[owner] - 1));
                end
`ifdef FRAME_LENGTH_CHECK_EN
                check_eq("length_error", 32'(length_error), 32'(lerr));
`endif
            end
            @(posedge clk);
            if (rst) model_reset();
            else advance();
            #1;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
